// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction memory and ID-side handshake bundle for fetch_unit
interface fetch_unit_if #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
);
  logic              mem_req_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_gnt_i;
  logic              mem_rvalid_i;
  logic [INST_W-1:0] mem_rdata_i;
  logic              id_valid_o;
  logic [ADDR_W-1:0] id_pc_o;
  logic [INST_W-1:0] id_inst_o;
  logic              id_ready_i;
  logic              redirect_i;
  logic [ADDR_W-1:0] redirect_pc_i;

  // Fetch unit side
  modport master (
    output mem_req_o, mem_addr_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output id_valid_o, id_pc_o, id_inst_o,
    input  id_ready_i, redirect_i, redirect_pc_i
  );

  // Memory / decode side
  modport slave (
    input  mem_req_o, mem_addr_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  id_valid_o, id_pc_o, id_inst_o,
    output id_ready_i, redirect_i, redirect_pc_i
  );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - in-order instruction fetch queue with redirect flush; FETCH_PERF_EN adds stall/flush counters
module fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  fetch_unit_if.master bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_stall_o,
  output logic [31:0] perf_flush_o
`endif
);
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  localparam int                PW      = $clog2(DEPTH);
  localparam int                CW      = PW + 1;
  localparam logic [CW:0]       DEPTH_W = (CW + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(PC_STEP);

  logic [CW-1:0]     head, fill, tail, discard_cnt;
  logic [CW-1:0]     alloc_cnt, filled_cnt, inflight_cnt;
  logic [CW:0]       occupancy;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] pc_q   [DEPTH];
  logic [INST_W-1:0] inst_q [DEPTH];
  logic              req, issue, store, drop, pop, valid, redirect;

  // Queue occupancy, handshake decode and head presentation
  always_comb begin
    redirect     = bus.redirect_i;
    alloc_cnt    = tail - head;
    filled_cnt   = fill - head;
    inflight_cnt = alloc_cnt - filled_cnt;
    // Stale in-flight responses still own a slot until they come back.
    occupancy    = {1'b0, alloc_cnt} + {1'b0, discard_cnt};
    req          = rst && !redirect && (occupancy < DEPTH_W);
    issue        = req && bus.mem_gnt_i;
    // Responses landing in a redirect cycle belong to the old stream.
    drop         = bus.mem_rvalid_i && (redirect || (discard_cnt != '0));
    store        = bus.mem_rvalid_i && !drop;
    valid        = (filled_cnt != '0);
    pop          = valid && bus.id_ready_i && !redirect;
    bus.mem_req_o  = req;
    bus.mem_addr_o = fetch_pc;
    bus.id_valid_o = valid;
    bus.id_pc_o    = valid ? pc_q[head[PW-1:0]]   : '0;
    bus.id_inst_o  = valid ? inst_q[head[PW-1:0]] : '0;
  end

  // Fetch PC, queue pointers and stale-response discard counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc    <= RESET_PC;
      head        <= '0;
      fill        <= '0;
      tail        <= '0;
      discard_cnt <= '0;
    end else if (redirect) begin
      fetch_pc    <= {bus.redirect_pc_i[ADDR_W-1:2], 2'b00};
      head        <= '0;
      fill        <= '0;
      tail        <= '0;
      discard_cnt <= discard_cnt + inflight_cnt - CW'(bus.mem_rvalid_i);
    end else begin
      if (issue) begin
        tail     <= tail + CW'(1);
        fetch_pc <= fetch_pc + STEP;
      end
      if (store) fill <= fill + CW'(1);
      if (pop)   head <= head + CW'(1);
      if (drop)  discard_cnt <= discard_cnt - CW'(1);
    end
  end

  // Entry payload: PC captured at issue, instruction captured at response
  always_ff @(posedge clk) begin
    if (issue) pc_q[tail[PW-1:0]]   <= fetch_pc;
    if (store) inst_q[fill[PW-1:0]] <= bus.mem_rdata_i;
  end

`ifdef FETCH_PERF_EN
  logic [32:0] flush_sum;

  // Saturating sum of entries thrown away by a redirect
  always_comb begin
    flush_sum = {1'b0, perf_flush_o} + 33'(alloc_cnt);
  end

  // Saturating stall and flush event counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_o <= '0;
      perf_flush_o <= '0;
    end else begin
      if (valid && !bus.id_ready_i && (perf_stall_o != '1))
        perf_stall_o <= perf_stall_o + 32'd1;
      if (redirect)
        perf_flush_o <= flush_sum[32] ? '1 : flush_sum[31:0];
    end
  end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized self-checking bench for fetch_unit against a queue-level model
module tb_fetch_unit;
  localparam int          DEPTH = 4;
  localparam logic [31:0] K     = 32'hA5A5_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_unit_if #(.ADDR_W(32), .INST_W(32)) bus ();
  fetch_unit_if #(.ADDR_W(32), .INST_W(32)) bus2 ();
`ifdef FETCH_PERF_EN
  logic [31:0] perf_stall, perf_flush, perf_stall2, perf_flush2;
`endif

  fetch_unit #(.ADDR_W(32), .INST_W(32), .DEPTH(DEPTH), .RESET_PC(32'h0), .PC_STEP(4)) dut (
    .clk(clk), .rst(rst), .bus(bus)
`ifdef FETCH_PERF_EN
    , .perf_stall_o(perf_stall), .perf_flush_o(perf_flush)
`endif
  );

  fetch_unit #(.ADDR_W(32), .INST_W(32), .DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8), .PC_STEP(4)) dut_wrap (
    .clk(clk), .rst(rst), .bus(bus2)
`ifdef FETCH_PERF_EN
    , .perf_stall_o(perf_stall2), .perf_flush_o(perf_flush2)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // stimulus knobs
  int p_gnt, p_ready, p_redir, lat_min, lat_max;
  bit force_redir;
  logic [31:0] force_rpc;

  // reference model: PCs fetched since last redirect, in order, plus how many have data
  logic [31:0] live[$];
  int          filled, stale;
  logic [31:0] m_pc, m_stall, m_flush;

  // in-order memory with per-request latency
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  int          last_due, cyc, n_issue;

  // second instance (wrap-around reset PC) observation
  bit          pend2, got_iss2;
  logic [31:0] paddr2, first_iss2;
  logic [31:0] q2[$], q2i[$], after2[$];

  task automatic model_reset();
    live.delete();
    filled = 0; stale = 0; m_pc = 32'h0; m_stall = 0; m_flush = 0;
    mq_addr.delete(); mq_due.delete(); last_due = -1;
    pend2 = 0;
  endtask

  task automatic model_step();
    bit ex_req, ex_val, pop, iss;
    logic [31:0] ex_pc;
`ifdef FETCH_PERF_EN
    check("perf_stall", perf_stall, m_stall);
    check("perf_flush", perf_flush, m_flush);
`endif
    ex_req = !bus.redirect_i && (live.size() + stale < DEPTH);
    ex_val = filled > 0;
    ex_pc  = ex_val ? live[0] : 32'h0;
    check("mem_req", bus.mem_req_o, ex_req);
    if (ex_req && bus.mem_req_o) check("mem_addr", bus.mem_addr_o, m_pc);
    check("id_valid", bus.id_valid_o, ex_val);
    check("id_pc", bus.id_pc_o, ex_pc);
    check("id_inst", bus.id_inst_o, ex_val ? (ex_pc ^ K) : 32'h0);
    iss = ex_req && bus.mem_gnt_i;
    pop = ex_val && bus.id_ready_i && !bus.redirect_i;
    if (ex_val && !bus.id_ready_i) m_stall++;
    if (bus.redirect_i) begin
      m_flush += live.size();
      stale = stale + live.size() - filled - int'(bus.mem_rvalid_i);
      live.delete();
      filled = 0;
      m_pc = bus.redirect_pc_i & 32'hFFFF_FFFC;
    end else begin
      if (pop) begin
        void'(live.pop_front());
        filled--;
      end
      if (bus.mem_rvalid_i) begin
        if (stale > 0) stale--;
        else begin
          check("resp_slot", filled < live.size(), 1);
          filled++;
        end
      end
      if (iss) begin
        live.push_back(m_pc);
        m_pc += 32'd4;
      end
    end
  endtask

  task automatic cycle();
    int lat, due;
    @(posedge clk);
    #1;
    bus.mem_gnt_i  = ($urandom_range(0, 99) < p_gnt);
    bus.id_ready_i = ($urandom_range(0, 99) < p_ready);
    if (force_redir) begin
      bus.redirect_i    = 1'b1;
      bus.redirect_pc_i = force_rpc;
    end else begin
      bus.redirect_i    = ($urandom_range(0, 99) < p_redir);
      bus.redirect_pc_i = $urandom & 32'h0000_0FFF;
    end
    if (mq_due.size() > 0 && mq_due[0] <= cyc) begin
      bus.mem_rvalid_i = 1'b1;
      bus.mem_rdata_i  = mq_addr.pop_front() ^ K;
      void'(mq_due.pop_front());
    end else begin
      bus.mem_rvalid_i = 1'b0;
      bus.mem_rdata_i  = $urandom;
    end
    bus2.mem_gnt_i     = 1'b1;
    bus2.id_ready_i    = 1'b1;
    bus2.redirect_i    = (cyc == 8);
    bus2.redirect_pc_i = 32'h0000_0103;
    bus2.mem_rvalid_i  = pend2;
    bus2.mem_rdata_i   = paddr2 ^ K;
    @(negedge clk);
    model_step();
    if (bus.mem_req_o && bus.mem_gnt_i) begin
      n_issue++;
      lat = $urandom_range(lat_min, lat_max);
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mq_addr.push_back(bus.mem_addr_o);
      mq_due.push_back(due);
    end
    pend2  = bus2.mem_req_o && bus2.mem_gnt_i;
    paddr2 = bus2.mem_addr_o;
    if (pend2 && cyc > 8 && !got_iss2) begin
      got_iss2   = 1;
      first_iss2 = paddr2;
    end
    if (bus2.id_valid_o) begin
      if (cyc < 8) begin
        q2.push_back(bus2.id_pc_o);
        q2i.push_back(bus2.id_inst_o);
      end else if (cyc > 8) after2.push_back(bus2.id_pc_o);
    end
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wait_valid(input string tag, input logic [31:0] exp_pc);
    int n = 0;
    while (!bus.id_valid_o && n < 40) begin
      cycle();
      n++;
    end
    check({tag, "_seen"}, bus.id_valid_o, 1);
    check({tag, "_pc"}, bus.id_pc_o, exp_pc);
    check({tag, "_inst"}, bus.id_inst_o, exp_pc ^ K);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"}, bus.mem_req_o, 0);
    check({tag, "_valid"}, bus.id_valid_o, 0);
    check({tag, "_pc"}, bus.id_pc_o, 0);
    check({tag, "_inst"}, bus.id_inst_o, 0);
    check({tag, "_req2"}, bus2.mem_req_o, 0);
    check({tag, "_valid2"}, bus2.id_valid_o, 0);
`ifdef FETCH_PERF_EN
    check({tag, "_pstall"}, perf_stall, 0);
    check({tag, "_pflush"}, perf_flush, 0);
`endif
  endtask

  task automatic idle_inputs();
    bus.mem_gnt_i = 0; bus.mem_rvalid_i = 0; bus.mem_rdata_i = 0;
    bus.id_ready_i = 0; bus.redirect_i = 0; bus.redirect_pc_i = 0;
    bus2.mem_gnt_i = 0; bus2.mem_rvalid_i = 0; bus2.mem_rdata_i = 0;
    bus2.id_ready_i = 0; bus2.redirect_i = 0; bus2.redirect_pc_i = 0;
  endtask

  initial begin
    logic [31:0] start_pc;
    int          iss0;
    rst = 1'b0;
    idle_inputs();
    force_redir = 0; force_rpc = 0;
    cyc = 0; n_issue = 0; got_iss2 = 0; paddr2 = 0; first_iss2 = 0;
    model_reset();
    #3;
    check_reset_outputs("rst0");
    @(posedge clk);
    #2 rst = 1'b1;

    // streaming with a 1-cycle memory: first instruction visible two cycles after issue
    p_gnt = 100; p_ready = 100; p_redir = 0; lat_min = 1; lat_max = 1;
    for (int k = 0; k < 12; k++) begin
      cycle();
      if (k < 2)  check("p1_idle", bus.id_valid_o, 0);
      if (k == 2) begin
        check("p1_first_valid", bus.id_valid_o, 1);
        check("p1_first_pc", bus.id_pc_o, 32'h0);
        check("p1_first_inst", bus.id_inst_o, K);
      end
    end

    // stall: queue fills to DEPTH then stops requesting
    p_gnt = 0; run(6);
    start_pc = m_pc;
    iss0 = n_issue;
    p_gnt = 100; p_ready = 0; run(10);
    check("p2_issues", n_issue - iss0, DEPTH);
    check("p2_req_off", bus.mem_req_o, 0);
    check("p2_hold_pc", bus.id_pc_o, start_pc);
    p_ready = 100; run(12);

    // wrap-around instance: reset PC wrap and misaligned redirect
    check("wrap_count", q2.size() >= 3, 1);
    if (q2.size() >= 3) begin
      check("wrap_pc0", q2[0], 32'hFFFF_FFF8);
      check("wrap_pc1", q2[1], 32'hFFFF_FFFC);
      check("wrap_pc2", q2[2], 32'h0000_0000);
      check("wrap_inst0", q2i[0], 32'hFFFF_FFF8 ^ K);
    end
    check("wrap_redir_issued", got_iss2, 1);
    check("wrap_redir_addr", first_iss2, 32'h100);
    check("wrap_redir_pop", after2.size() > 0 ? after2[0] : 32'hDEAD_BEEF, 32'h100);

    // 3-cycle memory, redirect with two requests in flight
    p_gnt = 0; run(6);
    lat_min = 3; lat_max = 3;
    p_gnt = 100; run(2);
    force_redir = 1; force_rpc = 32'h100;
    cycle();
    check("p3_req_redir", bus.mem_req_o, 0);
    force_redir = 0;
    wait_valid("p3", 32'h100);

    // redirect during rvalid+pop, then a second redirect next cycle
    lat_min = 1; lat_max = 1; p_gnt = 100; p_ready = 100;
    run(5);
    force_redir = 1; force_rpc = 32'h180;
    cycle();
    check("p4_req_r1", bus.mem_req_o, 0);
    force_rpc = 32'h200;
    cycle();
    check("p4_req_r2", bus.mem_req_o, 0);
    force_redir = 0;
    wait_valid("p4", 32'h200);

    // random traffic
    p_gnt = 70; p_ready = 70; p_redir = 4; lat_min = 1; lat_max = 4;
    run(3000);
    p_redir = 15; lat_min = 1; lat_max = 2;
    run(1000);

    // asynchronous reset in the middle of traffic
    #2 rst = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    idle_inputs();
    model_reset();
    @(posedge clk);
    #2 rst = 1'b1;

    // five stall cycles, then a redirect with three entries allocated
    p_redir = 0; lat_min = 1; lat_max = 1;
    p_gnt = 100; p_ready = 0; run(3);
    p_gnt = 0; run(4);
    p_ready = 100; force_redir = 1; force_rpc = 32'h40;
    cycle();
    force_redir = 0;
    cycle();
`ifdef FETCH_PERF_EN
    check("p6_stall", perf_stall, 32'd5);
    check("p6_flush", perf_flush, 32'd3);
`endif
    p_gnt = 100;
    wait_valid("p6", 32'h40);
    p_gnt = 80; p_ready = 60; p_redir = 5; lat_min = 1; lat_max = 3;
    run(500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Parametrised instruction-fetch stage that replaces the fixed PC register plus IF/ID latch pair of the 5-stage RISC-V pipeline.
- Issues in-order requests to an instruction memory with a request/grant handshake and variable response latency.
- Buffers returned instructions with their PCs in a DEPTH-entry queue.
- Presents them to ID under a valid/ready handshake.
- Supports stall from ID and a redirect (branch/jump) that flushes all fetched and in-flight instructions.

Parameters:
ADDR_W, 32, PC / memory address width
INST_W, 32, instruction width
DEPTH, 4, queue entries and maximum in-flight requests; power of two, >= 2
RESET_PC, 0, first fetch address after reset
PC_STEP, 4, byte increment between sequential fetches

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
mem_req_o  out  1  fetch request valid
mem_addr_o  out  ADDR_W  fetch address, low 2 bits always 0
mem_gnt_i  in  1  request accepted this cycle (req && gnt = issue)
mem_rvalid_i  in  1  in-order response valid
mem_rdata_i  in  INST_W  response instruction
id_valid_o  out  1  instruction available to ID
id_pc_o  out  ADDR_W  PC of head instruction, 0 when !id_valid_o
id_inst_o  out  INST_W  head instruction, 0 when !id_valid_o
id_ready_i  in  1  ID accepts head (stall when low)
redirect_i  in  1  flush and restart fetch
redirect_pc_i  in  ADDR_W  new fetch PC; low 2 bits ignored (forced 0)

Behaviour:
- Reset (rst low, async): fetch_pc=RESET_PC; all pointers, counts and discard counter = 0; mem_req_o=0; id_valid_o=0; id_pc_o=0; id_inst_o=0.
- Circular queue with three pointers:
  - tail: allocated at issue, entry PC written = fetch_pc.
  - fill: data written on accepted response.
  - head: popped on id_valid_o && id_ready_i.
  - alloc_cnt = entries tail..head; filled_cnt = entries fill..head.
- mem_req_o = !redirect_i && (alloc_cnt + discard_cnt < DEPTH); mem_addr_o = fetch_pc.
- Issue (req && gnt): tail++, fetch_pc += PC_STEP (wraps modulo 2^ADDR_W).
- Response (mem_rvalid_i):
  - discard_cnt > 0: dropped, discard_cnt--.
  - otherwise: stored at fill, fill++.
- id_valid_o = filled_cnt > 0, combinational from queue head. Pop, issue and response are all legal in the same cycle.
- Latency: with a 1-cycle memory, issue in cycle N, rvalid in N+1, id_valid_o in N+2. Back-to-back grants with ready high sustain 1 instruction/cycle.
- Full: alloc_cnt + discard_cnt == DEPTH → mem_req_o=0 until a pop or discard retires. Never drops a response.
- Redirect (redirect_i=1), at the edge:
  - head=fill=tail reset to 0; discard_cnt += (alloc_cnt - filled_cnt); fetch_pc = {redirect_pc_i[ADDR_W-1:2],2'b0}.
  - A response arriving in the redirect cycle is discarded (counted as in-flight). A pop in the redirect cycle is ignored.
  - mem_req_o=0 during the redirect cycle. Fetch resumes the next cycle at the new PC.
- Back-to-back redirects: the last one wins; discard counts accumulate.
- id_ready_i with id_valid_o low: no effect.
- Reset asserted mid-operation: state clears immediately. Responses to pre-reset requests are the memory's responsibility to squash.

Optional Feature:
Macro FETCH_PERF_EN.
- Defined: adds outputs perf_stall_o (32, out) and perf_flush_o (32, out), both reset to 0, saturating at all-ones.
  - perf_stall_o increments each cycle id_valid_o && !id_ready_i.
  - perf_flush_o increments by (alloc_cnt) on each redirect.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
1. Reset release, gnt=1, 1-cycle memory returning mem[a]=a^32'hA5A5_0000, ready=1 → addresses 0,4,8,... issued every cycle; id_valid_o from cycle 2; id_pc_o/id_inst_o stream 0/0xA5A50000, 4/0xA5A50004, ...
2. ready held 0 for 10 cycles with DEPTH=4 → exactly 4 issues, then mem_req_o=0; id_pc_o holds 0. Releasing ready resumes with no loss or duplication.
3. 3-cycle memory latency, redirect_pc_i=0x100 with 2 requests in flight → both late responses dropped; next id_pc_o=0x100 with mem[0x100] data.
4. Redirect in the same cycle as rvalid and pop; then a second redirect to 0x200 next cycle → only 0x200 stream appears; mem_req_o low in both redirect cycles.
5. RESET_PC=32'hFFFF_FFF8 → PCs FFFF_FFF8, FFFF_FFFC, 0000_0000 (wrap). redirect_pc_i=0x103 → fetch at 0x100.
6. FETCH_PERF_EN: 5 stall cycles, then a redirect with 3 allocated entries → perf_stall_o=5, perf_flush_o=3. Reset mid-run → all outputs 0 asynchronously.
